// File: rtl/exhaustive_sweep_gen_if.sv
// Handshake and data bundle between a sweep controller and exhaustive_sweep_gen.
// The golden_sig/pass/fail signals exist only when SWEEP_GOLDEN_CMP_EN is defined.
interface exhaustive_sweep_gen_if #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = 2,
  parameter int unsigned SIG_W = 16
) ();
  logic              start;
  logic              abort;
  logic [1:0]        mode;
  logic [OUT_W-1:0]  resp;
  logic [IN_W-1:0]   stim;
  logic              stim_valid;
  logic              busy;
  logic              done;
  logic [IN_W:0]     vec_count;
  logic [SIG_W-1:0]  signature;
`ifdef SWEEP_GOLDEN_CMP_EN
  logic [SIG_W-1:0]  golden_sig;
  logic              pass;
  logic              fail;
`endif

  modport master (
    output start, abort, mode, resp,
`ifdef SWEEP_GOLDEN_CMP_EN
    output golden_sig,
    input  pass, fail,
`endif
    input  stim, stim_valid, busy, done, vec_count, signature
  );

  modport slave (
    input  start, abort, mode, resp,
`ifdef SWEEP_GOLDEN_CMP_EN
    input  golden_sig,
    output pass, fail,
`endif
    output stim, stim_valid, busy, done, vec_count, signature
  );
endinterface

// File: rtl/exhaustive_sweep_gen.sv
// Exhaustive stimulus sequencer: walks all 2^IN_W vectors (up/Gray/down) and MISR-compacts the response.
// Optional golden-signature compare is enabled with SWEEP_GOLDEN_CMP_EN.
//
// state   | meaning
// S_IDLE  | waiting for start; outputs inactive
// S_DRIVE | driving vectors, compacting resp on the last hold cycle
// S_DONE  | sweep complete; stim, signature and vec_count frozen
module exhaustive_sweep_gen #(
  parameter int unsigned      IN_W     = 4,
  parameter int unsigned      OUT_W    = 2,
  parameter int unsigned      HOLD_CYC = 10,
  parameter int unsigned      SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021,
  parameter logic [SIG_W-1:0] SIG_SEED = '0
) (
  input logic                  clk,
  input logic                  rst_n,
  exhaustive_sweep_gen_if.slave sweep_if
);

  localparam int unsigned     HW        = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [IN_W-1:0] IDX_LAST  = '1;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_e;

  state_e           state_q;
  logic [1:0]       mode_q;
  logic [IN_W-1:0]  idx_q;
  logic [HW-1:0]    hold_q;
  logic [IN_W-1:0]  stim_q;
  logic             busy_q;
  logic             valid_q;
  logic             done_q;
  logic [IN_W:0]    cnt_q;
  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;
  logic             accept;
  logic             last_hold;
  logic             last_vec;
`ifdef SWEEP_GOLDEN_CMP_EN
  logic             pass_q;
  logic             fail_q;
`endif

  function automatic logic [IN_W-1:0] map_stim(input logic [IN_W-1:0] i, input logic [1:0] m);
    case (m)
      2'b01:   map_stim = i ^ (i >> 1);
      2'b10:   map_stim = ~i;
      default: map_stim = i;
    endcase
  endfunction

  assign accept    = sweep_if.start && !sweep_if.abort && (state_q != S_DRIVE);
  assign last_hold = (hold_q == HOLD_LAST);
  assign last_vec  = (idx_q == IDX_LAST);

  always_comb begin
    sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? SIG_POLY : '0) ^ SIG_W'(sweep_if.resp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 2'b00;
      idx_q   <= '0;
      hold_q  <= '0;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      sig_q   <= SIG_SEED;
`ifdef SWEEP_GOLDEN_CMP_EN
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state_q <= S_DRIVE;
            mode_q  <= sweep_if.mode;
            idx_q   <= '0;
            hold_q  <= '0;
            stim_q  <= map_stim('0, sweep_if.mode);
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            sig_q   <= SIG_SEED;
`ifdef SWEEP_GOLDEN_CMP_EN
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
`endif
          end
        end
        S_DRIVE: begin
          if (sweep_if.abort) begin
            // Partial signature and count are kept for post-mortem.
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef SWEEP_GOLDEN_CMP_EN
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
`endif
          end else if (last_hold) begin
            sig_q <= sig_d;
            cnt_q <= cnt_q + 1'b1;
            if (last_vec) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
`ifdef SWEEP_GOLDEN_CMP_EN
              pass_q  <= (sig_d == sweep_if.golden_sig);
              fail_q  <= (sig_d != sweep_if.golden_sig);
`endif
            end else begin
              idx_q  <= idx_q + 1'b1;
              hold_q <= '0;
              stim_q <= map_stim(idx_q + 1'b1, mode_q);
            end
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sweep_if.stim       = stim_q;
  assign sweep_if.stim_valid = valid_q;
  assign sweep_if.busy       = busy_q;
  assign sweep_if.done       = done_q;
  assign sweep_if.vec_count  = cnt_q;
  assign sweep_if.signature  = sig_q;
`ifdef SWEEP_GOLDEN_CMP_EN
  assign sweep_if.pass       = pass_q;
  assign sweep_if.fail       = fail_q;
`endif

endmodule

// File: tb/tb_exhaustive_sweep_gen.sv
// Randomized self-checking bench for exhaustive_sweep_gen against a sweep-level reference model.
// Golden-compare checks are included when SWEEP_GOLDEN_CMP_EN is defined.
`timescale 1ns/1ps
module tb_exhaustive_sweep_gen;
  localparam int unsigned      IN_W     = 4;
  localparam int unsigned      OUT_W    = 2;
  localparam int unsigned      HOLD_CYC = 10;
  localparam int unsigned      SIG_W    = 16;
  localparam logic [SIG_W-1:0] SIG_POLY = 16'h1021;
  localparam logic [SIG_W-1:0] SIG_SEED = '0;
  localparam int               NV       = 1 << IN_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exhaustive_sweep_gen_if #(.IN_W(IN_W), .OUT_W(OUT_W), .SIG_W(SIG_W)) sif ();

  exhaustive_sweep_gen #(
    .IN_W(IN_W), .OUT_W(OUT_W), .HOLD_CYC(HOLD_CYC), .SIG_W(SIG_W),
    .SIG_POLY(SIG_POLY), .SIG_SEED(SIG_SEED)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sweep_if(sif)
  );

  int n_checks = 0;
  int n_errors = 0;
  int resp_sel = 0;
  logic [OUT_W-1:0] lut [NV];

  // Stand-in combinational logic under test: zero, low stim bits, or a random truth table.
  assign sif.resp = (resp_sel == 0) ? '0 :
                    (resp_sel == 1) ? sif.stim[OUT_W-1:0] : lut[sif.stim];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_stim(input int m, input int v);
    case (m)
      1:       exp_stim = v ^ (v >> 1);
      2:       exp_stim = NV - 1 - v;
      default: exp_stim = v;
    endcase
  endfunction

  function automatic int model_resp(input int s);
    if (resp_sel == 0)      model_resp = 0;
    else if (resp_sel == 1) model_resp = s % (1 << OUT_W);
    else                    model_resp = int'(lut[s]);
  endfunction

  function automatic int model_sig(input int m, input int nvec);
    int sig = int'(SIG_SEED);
    for (int v = 0; v < nvec; v++) begin
      int top = (sig >> (SIG_W - 1)) & 1;
      sig = (sig * 2) % (1 << SIG_W);
      if (top == 1) sig = sig ^ int'(SIG_POLY);
      sig = sig ^ model_resp(exp_stim(m, v));
    end
    model_sig = sig;
  endfunction

  // Returns at the first falling edge after the accepting rising edge (vector 0, hold 0).
  task automatic start_sweep(input int m);
    @(negedge clk);
    sif.start = 1'b1;
    sif.abort = 1'b0;
    sif.mode  = 2'(m);
    @(negedge clk);
    sif.start = 1'b0;
  endtask

  task automatic run_full(input int m);
    logic [IN_W-1:0] prev;
    prev = '0;
    start_sweep(m);
    chk("busy_after_start", 32'(sif.busy), 1);
    chk("valid_after_start", 32'(sif.stim_valid), 1);
    chk("cnt_after_start", 32'(sif.vec_count), 0);
    chk("sig_after_start", 32'(sif.signature), 32'(SIG_SEED));
`ifdef SWEEP_GOLDEN_CMP_EN
    chk("pass_cleared", 32'(sif.pass), 0);
    chk("fail_cleared", 32'(sif.fail), 0);
`endif
    for (int k = 0; k < NV * HOLD_CYC; k++) begin
      int v;
      int h;
      v = k / HOLD_CYC;
      h = k % HOLD_CYC;
      if (h == 0 || h == HOLD_CYC - 1) chk("stim", 32'(sif.stim), 32'(exp_stim(m, v)));
      if (h == HOLD_CYC - 1) chk("vec_count_run", 32'(sif.vec_count), 32'(v));
      if (m == 1 && h == 0 && v > 0) chk("gray_1bit", 32'($countones(sif.stim ^ prev)), 1);
      if (h == 0) prev = sif.stim;
      if (k == NV * HOLD_CYC - 1) begin
        chk("done_early", 32'(sif.done), 0);
        chk("busy_last", 32'(sif.busy), 1);
      end
      sif.mode  = 2'($urandom_range(0, 3));
      sif.start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    sif.start = 1'b0;
    chk("done_latency", 32'(sif.done), 1);
    chk("busy_done", 32'(sif.busy), 0);
    chk("valid_done", 32'(sif.stim_valid), 0);
    chk("vec_count_final", 32'(sif.vec_count), 32'(NV));
    chk("signature_final", 32'(sif.signature), 32'(model_sig(m, NV)));
    chk("stim_frozen", 32'(sif.stim), 32'(exp_stim(m, NV - 1)));
`ifdef SWEEP_GOLDEN_CMP_EN
    chk("pass", 32'(sif.pass), 32'(model_sig(m, NV) == int'(sif.golden_sig)));
    chk("fail", 32'(sif.fail), 32'(model_sig(m, NV) != int'(sif.golden_sig)));
`endif
    repeat (2) @(negedge clk);
    chk("done_held", 32'(sif.done), 1);
    chk("sig_held", 32'(sif.signature), 32'(model_sig(m, NV)));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_stim"}, 32'(sif.stim), 0);
    chk({tag, "_valid"}, 32'(sif.stim_valid), 0);
    chk({tag, "_busy"}, 32'(sif.busy), 0);
    chk({tag, "_done"}, 32'(sif.done), 0);
    chk({tag, "_cnt"}, 32'(sif.vec_count), 0);
    chk({tag, "_sig"}, 32'(sif.signature), 32'(SIG_SEED));
  endtask

  initial begin
    sif.start = 1'b0;
    sif.abort = 1'b0;
    sif.mode  = 2'b00;
`ifdef SWEEP_GOLDEN_CMP_EN
    sif.golden_sig = '0;
`endif
    foreach (lut[i]) lut[i] = OUT_W'($urandom);
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    resp_sel = 0; run_full(0);
    resp_sel = 1; run_full(1);
    resp_sel = 1; run_full(2);
    run_full(2);
    resp_sel = 2; run_full(3);
    for (int r = 0; r < 3; r++) begin
      foreach (lut[i]) lut[i] = OUT_W'($urandom);
      resp_sel = int'($urandom_range(0, 2));
      run_full(int'($urandom_range(0, 3)));
    end

    // start together with abort while in DONE: nothing starts, DONE is kept
    sif.start = 1'b1; sif.abort = 1'b1;
    @(negedge clk);
    sif.start = 1'b0; sif.abort = 1'b0;
    chk("done_abort_start_busy", 32'(sif.busy), 0);
    chk("done_abort_start_done", 32'(sif.done), 1);
    chk("done_abort_start_cnt", 32'(sif.vec_count), 32'(NV));

    // abort on the 3rd clock of vector 5, with a simultaneous start
    resp_sel = 2;
    foreach (lut[i]) lut[i] = OUT_W'($urandom);
    start_sweep(0);
    repeat (5 * HOLD_CYC + 2) @(negedge clk);
    sif.abort = 1'b1; sif.start = 1'b1;
    @(negedge clk);
    sif.abort = 1'b0; sif.start = 1'b0;
    chk("abort_busy", 32'(sif.busy), 0);
    chk("abort_valid", 32'(sif.stim_valid), 0);
    chk("abort_done", 32'(sif.done), 0);
    chk("abort_cnt", 32'(sif.vec_count), 5);
    chk("abort_sig", 32'(sif.signature), 32'(model_sig(0, 5)));
    @(negedge clk);
    chk("abort_idle_busy", 32'(sif.busy), 0);
    sif.start = 1'b1; sif.abort = 1'b1;
    @(negedge clk);
    sif.start = 1'b0; sif.abort = 1'b0;
    chk("idle_abort_wins", 32'(sif.busy), 0);
    chk("idle_abort_cnt", 32'(sif.vec_count), 5);

    // abort on the last hold cycle of vector 0: no MISR update on that edge
    start_sweep(2);
    repeat (HOLD_CYC - 1) @(negedge clk);
    sif.abort = 1'b1;
    @(negedge clk);
    sif.abort = 1'b0;
    chk("abort_last_cnt", 32'(sif.vec_count), 0);
    chk("abort_last_sig", 32'(sif.signature), 32'(SIG_SEED));

`ifdef SWEEP_GOLDEN_CMP_EN
    resp_sel = 2;
    sif.golden_sig = SIG_W'(model_sig(0, NV));
    run_full(0);
    chk("golden_pass", 32'(sif.pass), 1);
    sif.golden_sig = SIG_W'(model_sig(0, NV)) ^ SIG_W'(1);
    run_full(0);
    chk("golden_fail", 32'(sif.fail), 1);
`endif

    // asynchronous reset in the middle of a sweep
    resp_sel = 1;
    start_sweep(1);
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
`ifdef SWEEP_GOLDEN_CMP_EN
    chk("async_rst_pass", 32'(sif.pass), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", 32'(sif.busy), 0);
    chk("post_rst_done", 32'(sif.done), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
